// File: rtl/counter.sv
// counter: free-running up/down counter with programmable terminal value and wrap pulse
module counter #(
    parameter int              WIDTH       = 4,
    parameter longint unsigned MAX_VALUE   = (64'd1 << WIDTH) - 64'd1,
    parameter bit              COUNT_UP    = 1'b1,
    parameter longint unsigned RESET_VALUE = 64'd0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] MAX = MAX_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST = RESET_VALUE[WIDTH-1:0];
    if (WIDTH < 1 || WIDTH > 32 || MAX_VALUE == 0 || MAX_VALUE > (64'd1 << WIDTH) - 64'd1 ||
        RESET_VALUE > MAX_VALUE) begin : g_param_check
        $error("counter: illegal WIDTH/MAX_VALUE/RESET_VALUE combination");
    end
    logic [WIDTH-1:0] count_q = RST;
    logic             wrap_q  = 1'b0;
    logic [WIDTH:0]   step;
    logic             term;
    logic [WIDTH-1:0] nxt;
    // one step in the count direction; a down-count from 0 borrows into the top bit
    // so 0 and any out-of-range value both compare as terminal
    always_comb begin
        step = COUNT_UP ? {1'b0, count_q} + 1'b1 : {1'b0, count_q} - 1'b1;
        term = COUNT_UP ? (step > {1'b0, MAX}) : (step >= {1'b0, MAX});
        nxt  = term ? (COUNT_UP ? '0 : MAX) : step[WIDTH-1:0];
    end
    // synchronous active-low reset overrides counting and suppresses the wrap pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= RST;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= nxt;
            wrap_q  <= term;
        end
    end
    assign count = count_q;
    assign wrap  = wrap_q;
endmodule

// File: tb/tb_counter.sv
// tb_counter: directed checks of up, down and short-modulus counter configurations
module tb_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] c_up, c_dn, c_m12;
    logic       w_up, w_dn, w_m12;
    int         passed = 0;
    int         total = 0;
    always #5 clk = ~clk;
    counter u_up (.clk(clk), .reset(reset), .count(c_up), .wrap(w_up));
    counter #(.MAX_VALUE(9), .COUNT_UP(1'b0)) u_dn (.clk(clk), .reset(reset), .count(c_dn), .wrap(w_dn));
    counter #(.MAX_VALUE(11)) u_m12 (.clk(clk), .reset(reset), .count(c_m12), .wrap(w_m12));
    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask
    initial begin
        #1;
        check("pwr_up", c_up, 0);
        check("pwr_up_wrap", w_up, 0);
        check("pwr_dn", c_dn, 0);
        repeat (3) begin
            @(negedge clk);
            check("rst_up", c_up, 0);
            check("rst_up_wrap", w_up, 0);
            check("rst_dn", c_dn, 0);
            check("rst_m12", c_m12, 0);
        end
        reset = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            check("run_up", c_up, k % 16);
            check("run_up_wrap", w_up, k == 16);
            check("run_dn", c_dn, (10 - k % 10) % 10);
            check("run_dn_wrap", w_dn, k % 10 == 1);
            check("run_m12", c_m12, k % 12);
            check("run_m12_wrap", w_m12, k % 12 == 0);
        end
        check("pre_rst_up", c_up, 9);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_up", c_up, 0);
        check("mid_rst_up_wrap", w_up, 0);
        check("mid_rst_dn", c_dn, 0);
        check("mid_rst_dn_wrap", w_dn, 0);
        check("mid_rst_m12", c_m12, 0);
        reset = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            check("resume_up", c_up, j);
            check("resume_dn", c_dn, 10 - j);
            check("resume_dn_wrap", w_dn, j == 1);
            check("resume_m12", c_m12, j);
        end
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        check("glitch_up", c_up, 4);
        check("glitch_up_wrap", w_up, 0);
        check("glitch_dn", c_dn, 6);
        check("glitch_m12", c_m12, 4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
